// File: rtl/mux_sel_pipe_pkg.sv
// Shared constants and helpers for the selectable mux pipeline.
// Holds mode encodings and the clog2 width helper.
package mux_pipe_pkg;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_sel_pipe_if.sv
// Bus bundle for mux_sel_pipe: mode/select, N input channels, one output.
// master drives channels and out_ready; slave is the pipeline.
interface mux_sel_pipe_if
  import mux_pipe_pkg::*;
#(
  parameter int W = 5,
  parameter int N = 3
);
  localparam int SW = (clog2(N) > 1) ? clog2(N) : 1;

  logic           mode;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_sel, out_valid
  );

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_sel, out_valid
  );
endinterface

// File: rtl/mux_sel_pipe_rr_arbiter.sv
// Combinational round-robin grant: first req after ptr, wrapping mod N.
// Ports: req[N], ptr -> gnt_idx, gnt_any.
module rr_arbiter
  import mux_pipe_pkg::*;
#(
  parameter int N = 3,
  localparam int SW = (clog2(N) > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  // Scan farthest-first so the nearest candidate wins the last write.
  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        gnt_any = 1'b1;
        gnt_idx = SW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/mux_sel_pipe.sv
// N-to-1 mux into a one-stage output register, explicit select or RR.
// Ports: clk, rst_n (async, low), bus (mux_sel_pipe_if.slave).
module mux_sel_pipe
  import mux_pipe_pkg::*;
#(
  parameter int W = 5,
  parameter int N = 3
) (
  input logic          clk,
  input logic          rst_n,
  mux_sel_pipe_if.slave bus
);
  localparam int SW = (clog2(N) > 1) ? clog2(N) : 1;

  logic [SW-1:0] rr_ptr;
  logic [SW-1:0] eff;
  logic [SW-1:0] arb_idx;
  logic          arb_any;
  logic [SW-1:0] idx;
  logic          gnt;
  logic          can_load;
  logic          xfer;
  logic [N-1:0]  rdy;
  logic [W-1:0]  data_q;
  logic [SW-1:0] sel_q;
  logic          valid_q;

  rr_arbiter #(.N(N)) u_arb (
    .req     (bus.in_valid),
    .ptr     (rr_ptr),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  assign eff = (int'(bus.sel) < N) ? bus.sel : SW'(N - 1);
  assign can_load = !valid_q || bus.out_ready;

  // Explicit mode offers ready to eff even if it is not valid.
  assign idx = (bus.mode == MODE_RR) ? arb_idx : eff;
  assign gnt = (bus.mode == MODE_RR) ? arb_any : 1'b1;

  always_comb begin
    rdy = '0;
    if (rst_n && can_load && gnt) rdy[idx] = 1'b1;
  end

  assign xfer = |(rdy & bus.in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      rr_ptr  <= SW'(N - 1);
    end else begin
      if (xfer) begin
        valid_q <= 1'b1;
        data_q  <= bus.in_data[int'(idx)*W +: W];
        sel_q   <= idx;
        if (bus.mode == MODE_RR) rr_ptr <= idx;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_data  = data_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_mux_sel_pipe.sv
// Directed bench for mux_sel_pipe (W=5, N=3): vector table plus
// hand-written reset sequence.
module tb_mux_sel_pipe;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  mux_sel_pipe_if #(.W(5), .N(3)) bus ();

  mux_sel_pipe #(.W(5), .N(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mode;
    logic [1:0]  sel;
    logic [14:0] data;
    logic [2:0]  valid;
    logic        ordy;
    logic [2:0]  rdy;
    logic        ov;
    logic [4:0]  od;
    logic [1:0]  os;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(
    input logic m, input logic [1:0] s, input logic [14:0] d,
    input logic [2:0] v, input logic r, input logic [2:0] er,
    input logic eov, input logic [4:0] eod, input logic [1:0] eos);
    vec_t t;
    t.mode = m; t.sel = s; t.data = d; t.valid = v; t.ordy = r;
    t.rdy = er; t.ov = eov; t.od = eod; t.os = eos;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    bus.mode      = t.mode;
    bus.sel       = t.sel;
    bus.in_data   = t.data;
    bus.in_valid  = t.valid;
    bus.out_ready = t.ordy;
  endtask

  logic [14:0] d1;
  logic [14:0] d2;

  initial begin
    tests = 0;
    fails = 0;
    d1 = {5'd9, 5'd7, 5'd3};
    d2 = {5'd31, 5'd17, 5'd1};

    tbl[0]  = mk(0, 1, d1, 3'b111, 1, 3'b010, 1, 7, 1);
    tbl[1]  = mk(0, 3, d1, 3'b111, 1, 3'b100, 1, 9, 2);
    tbl[2]  = mk(0, 0, d1, 3'b110, 1, 3'b001, 0, 9, 2);
    tbl[3]  = mk(0, 0, d1, 3'b001, 0, 3'b001, 1, 3, 0);
    tbl[4]  = mk(1, 0, d1, 3'b111, 1, 3'b001, 1, 3, 0);
    tbl[5]  = mk(1, 0, d1, 3'b111, 1, 3'b010, 1, 7, 1);
    tbl[6]  = mk(1, 0, d1, 3'b111, 1, 3'b100, 1, 9, 2);
    tbl[7]  = mk(1, 0, d1, 3'b111, 1, 3'b001, 1, 3, 0);
    tbl[8]  = mk(1, 0, d1, 3'b111, 1, 3'b010, 1, 7, 1);
    tbl[9]  = mk(1, 0, d1, 3'b111, 1, 3'b100, 1, 9, 2);
    tbl[10] = mk(1, 0, d1, 3'b111, 0, 3'b000, 1, 9, 2);
    tbl[11] = mk(1, 0, d1, 3'b111, 0, 3'b000, 1, 9, 2);
    tbl[12] = mk(1, 0, d1, 3'b111, 0, 3'b000, 1, 9, 2);
    tbl[13] = mk(1, 0, d1, 3'b111, 1, 3'b001, 1, 3, 0);
    tbl[14] = mk(1, 0, d1, 3'b101, 1, 3'b100, 1, 9, 2);
    tbl[15] = mk(1, 0, d1, 3'b101, 1, 3'b001, 1, 3, 0);
    tbl[16] = mk(1, 0, d1, 3'b101, 1, 3'b100, 1, 9, 2);
    tbl[17] = mk(1, 0, d1, 3'b000, 1, 3'b000, 0, 9, 2);
    tbl[18] = mk(1, 0, d2, 3'b010, 1, 3'b010, 1, 17, 1);
    tbl[19] = mk(0, 2, d2, 3'b111, 0, 3'b000, 1, 17, 1);

    rst_n = 1'b0;
    drive(tbl[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst out_valid", 32'(bus.out_valid), 0);
    chk("rst out_data", 32'(bus.out_data), 0);
    chk("rst out_sel", 32'(bus.out_sel), 0);
    chk("rst in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready),
          32'(tbl[i].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid),
          32'(tbl[i].ov));
      chk($sformatf("v%0d out_data", i), 32'(bus.out_data),
          32'(tbl[i].od));
      chk($sformatf("v%0d out_sel", i), 32'(bus.out_sel),
          32'(tbl[i].os));
    end

    // Mid-stream reset while an item is held: clears before any edge.
    chk("pre-rst out_valid", 32'(bus.out_valid), 1);
    drive(mk(1, 0, d1, 3'b111, 0, 3'b000, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid-rst out_valid", 32'(bus.out_valid), 0);
    chk("mid-rst out_data", 32'(bus.out_data), 0);
    chk("mid-rst out_sel", 32'(bus.out_sel), 0);
    chk("mid-rst in_ready", 32'(bus.in_ready), 0);
    @(posedge clk);
    #1;
    chk("in-rst out_valid", 32'(bus.out_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("post-rst in_ready", 32'(bus.in_ready), 3'b001);
    chk("post-rst out_valid", 32'(bus.out_valid), 0);
    @(posedge clk);
    #1;
    chk("post-rst first out_valid", 32'(bus.out_valid), 1);
    chk("post-rst first out_sel", 32'(bus.out_sel), 0);
    chk("post-rst first out_data", 32'(bus.out_data), 3);
    @(posedge clk);
    #1;
    chk("post-rst second out_sel", 32'(bus.out_sel), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
